// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - BCD types, limits and helpers shared by the time-of-day path.
package clock_pkg;

  typedef logic [3:0] bcd_nibble_t;
  typedef logic [7:0] bcd_byte_t;

  localparam bcd_byte_t BCD_59 = 8'h59;
  localparam bcd_byte_t BCD_23 = 8'h23;

  // Both nibbles must be decimal digits before the byte compare is meaningful
  function automatic logic bcd_valid(input bcd_byte_t v, input bcd_byte_t lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

  function automatic bcd_byte_t to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// rtl/bcd_digit_pair.sv - two-digit BCD counter wrapping at MAX, with parallel load.
module bcd_digit_pair
  import clock_pkg::*;
#(
  parameter bcd_byte_t MAX = BCD_59
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      Inc,
  input  logic      Load,
  input  bcd_byte_t LoadVal,
  output bcd_byte_t Value,
  output logic      Wrap
);

  bcd_byte_t r_value;
  bcd_byte_t w_next;
  logic      w_at_max;

  assign w_at_max = (r_value == MAX);

  always_comb begin
    w_next = r_value;
    if (Load) begin
      w_next = LoadVal;
    end else if (Inc) begin
      if (w_at_max) begin
        w_next = '0;
      end else if (r_value[3:0] == 4'd9) begin
        w_next = {r_value[7:4] + 4'd1, 4'd0};
      end else begin
        w_next = {r_value[7:4], r_value[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign Value = r_value;
  // Carry-out is combinational so the next stage advances on the same edge
  assign Wrap  = Inc && !Load && w_at_max;

endmodule

// File: rtl/clock_counter_24h.sv
// rtl/clock_counter_24h.sv - 24-hour BCD time-of-day counter with validated load and pause.
module clock_counter_24h
  import clock_pkg::*;
#(
  parameter int MAX_HOUR   = 23,
  parameter int MAX_MINSEC = 59
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Tick,
  input  logic       Pause,
  input  logic       Load,
  input  logic [7:0] SetH,
  input  logic [7:0] SetM,
  input  logic [7:0] SetS,
  output logic [7:0] Hours,
  output logic [7:0] Minutes,
  output logic [7:0] Seconds,
  output logic       MinTick,
  output logic       DayTick,
  output logic       LoadErr
);

  localparam bcd_byte_t LIM_H  = to_bcd(MAX_HOUR);
  localparam bcd_byte_t LIM_MS = to_bcd(MAX_MINSEC);

  logic w_set_valid;
  logic w_load_ok;
  logic w_advance;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hour_wrap;

  logic r_min_tick;
  logic r_day_tick;
  logic r_load_err;

  assign w_set_valid = bcd_valid(SetH, LIM_H) && bcd_valid(SetM, LIM_MS) &&
                       bcd_valid(SetS, LIM_MS);
  assign w_load_ok   = Load && w_set_valid;
  // Load outranks Pause outranks Tick; a Tick lost to a Load is simply dropped
  assign w_advance   = Tick && !Pause && !Load;

  bcd_digit_pair #(.MAX(LIM_MS)) u_sec (
    .CLK     (CLK),
    .RST     (RST),
    .Inc     (w_advance),
    .Load    (w_load_ok),
    .LoadVal (SetS),
    .Value   (Seconds),
    .Wrap    (w_sec_wrap)
  );

  bcd_digit_pair #(.MAX(LIM_MS)) u_min (
    .CLK     (CLK),
    .RST     (RST),
    .Inc     (w_sec_wrap),
    .Load    (w_load_ok),
    .LoadVal (SetM),
    .Value   (Minutes),
    .Wrap    (w_min_wrap)
  );

  bcd_digit_pair #(.MAX(LIM_H)) u_hour (
    .CLK     (CLK),
    .RST     (RST),
    .Inc     (w_min_wrap),
    .Load    (w_load_ok),
    .LoadVal (SetH),
    .Value   (Hours),
    .Wrap    (w_hour_wrap)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_min_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_min_tick <= w_sec_wrap;
      r_day_tick <= w_hour_wrap;
      r_load_err <= Load && !w_set_valid;
    end
  end

  assign MinTick = r_min_tick;
  assign DayTick = r_day_tick;
  assign LoadErr = r_load_err;

endmodule

// File: tb/tb_clock_counter_24h.sv
// tb/tb_clock_counter_24h.sv - directed self-checking bench for clock_counter_24h.
module tb_clock_counter_24h;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Tick = 1'b0;
  logic       Pause = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] SetH = '0;
  logic [7:0] SetM = '0;
  logic [7:0] SetS = '0;
  logic [7:0] Hours;
  logic [7:0] Minutes;
  logic [7:0] Seconds;
  logic       MinTick;
  logic       DayTick;
  logic       LoadErr;

  int n_tests = 0;
  int n_fail  = 0;

  clock_counter_24h dut (
    .CLK     (CLK),
    .RST     (RST),
    .Tick    (Tick),
    .Pause   (Pause),
    .Load    (Load),
    .SetH    (SetH),
    .SetM    (SetM),
    .SetS    (SetS),
    .Hours   (Hours),
    .Minutes (Minutes),
    .Seconds (Seconds),
    .MinTick (MinTick),
    .DayTick (DayTick),
    .LoadErr (LoadErr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic t, input logic p, input logic l, input logic [23:0] set);
    @(negedge CLK);
    Tick  = t;
    Pause = p;
    Load  = l;
    {SetH, SetM, SetS} = set;
    @(posedge CLK);
    #1;
    Tick = 1'b0;
    Load = 1'b0;
  endtask

  function automatic logic [23:0] now_time();
    return {Hours, Minutes, Seconds};
  endfunction

  int n_min;
  int n_day;

  initial begin
    #12;
    check("reset_time", {8'h0, now_time()}, 32'h0);
    check("reset_pulses", {29'h0, MinTick, DayTick, LoadErr}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // 60 ticks from midnight
    n_min = 0;
    n_day = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b0, 1'b0, 24'h0);
      n_min += int'(MinTick);
      n_day += int'(DayTick);
      if (i == 58) check("sec_59", {8'h0, now_time()}, 32'h000059);
      if (i == 59) begin
        check("one_minute", {8'h0, now_time()}, 32'h000100);
        check("mintick_aligned", {31'h0, MinTick}, 32'h1);
      end
    end
    check("mintick_count", n_min, 1);
    check("daytick_none", n_day, 0);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check("mintick_one_cycle", {31'h0, MinTick}, 32'h0);

    // Day wrap
    step(1'b0, 1'b0, 1'b1, 24'h235958);
    check("load_235958", {8'h0, now_time()}, 32'h235958);
    check("load_no_pulse", {29'h0, MinTick, DayTick, LoadErr}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("tick_235959", {8'h0, now_time()}, 32'h235959);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("day_wrap", {8'h0, now_time()}, 32'h000000);
    check("day_wrap_pulses", {30'h0, MinTick, DayTick}, 32'h3);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check("daytick_one_cycle", {31'h0, DayTick}, 32'h0);

    // Hour tens carry
    step(1'b0, 1'b0, 1'b1, 24'h095959);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("carry_09_10", {8'h0, now_time()}, 32'h100000);
    check("carry_09_pulses", {30'h0, MinTick, DayTick}, 32'h2);
    step(1'b0, 1'b0, 1'b1, 24'h195959);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("carry_19_20", {8'h0, now_time()}, 32'h200000);
    check("carry_19_pulses", {30'h0, MinTick, DayTick}, 32'h2);

    // Rejected loads
    step(1'b0, 1'b0, 1'b1, 24'h240000);
    check("err_24h", {7'h0, LoadErr, now_time()}, 32'h01200000);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check("loaderr_one_cycle", {31'h0, LoadErr}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 24'h125A00);
    check("err_nibble", {7'h0, LoadErr, now_time()}, 32'h01200000);
    step(1'b0, 1'b0, 1'b1, 24'h126000);
    check("err_60m", {7'h0, LoadErr, now_time()}, 32'h01200000);

    // Pause and precedence
    step(1'b0, 1'b0, 1'b1, 24'h010203);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 24'h0);
    check("paused", {8'h0, now_time()}, 32'h010203);
    step(1'b0, 1'b1, 1'b1, 24'h020304);
    check("load_while_paused", {8'h0, now_time()}, 32'h020304);
    step(1'b1, 1'b0, 1'b1, 24'h111111);
    check("load_beats_tick", {8'h0, now_time()}, 32'h111111);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("tick_after_load", {8'h0, now_time()}, 32'h111112);

    // Asynchronous reset mid-cycle
    step(1'b0, 1'b0, 1'b1, 24'h123456);
    check("load_123456", {8'h0, now_time()}, 32'h123456);
    #2;
    RST = 1'b0;
    #1;
    check("async_reset", {5'h0, MinTick, DayTick, LoadErr, now_time()}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("first_tick_after_reset", {8'h0, now_time()}, 32'h000001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/clock_counter_24h.md
# clock_counter_24h

Time-of-day counter that consumes the one-cycle second pulse and keeps hours, minutes and seconds as BCD digits for the 24-hour clock display path. It sits between the second-tick generator and the seven-segment display driver. It supports a validated parallel time load and a pause control, and it emits carry pulses for downstream alarm and date logic.

## Interface
- MAX_HOUR, 23: last hour value before wrap to 00.
- MAX_MINSEC, 59: last minute and second value before wrap to 00.
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  asynchronous, active-low reset.
- Tick  in  1  one-cycle pulse, one per second, synchronous to CLK.
- Pause  in  1  level; while high, Tick is ignored and time holds.
- Load  in  1  one-cycle request to load SetH/SetM/SetS.
- SetH  in  8  BCD hours, {tens[3:0], units[3:0]}.
- SetM  in  8  BCD minutes.
- SetS  in  8  BCD seconds.
- Hours  out  8  BCD hours, registered.
- Minutes  out  8  BCD minutes, registered.
- Seconds  out  8  BCD seconds, registered.
- MinTick  out  1  one-cycle pulse when seconds wrap 59→00.
- DayTick  out  1  one-cycle pulse when time wraps 23:59:59→00:00:00.
- LoadErr  out  1  one-cycle pulse when a Load is rejected.

## Operation
- Reset (RST low, asynchronous): Hours=Minutes=Seconds=8'h00; MinTick=DayTick=LoadErr=0.
- Advance: Tick=1, Pause=0, Load=0 → seconds increment in BCD.
  - Units 9→0 carries into tens.
  - Seconds 59→00 carries into minutes and asserts MinTick.
  - Minutes 59→00 carries into hours.
  - Hours 23→00 with minutes and seconds also wrapping asserts DayTick.
  - The hours wrap depends on the whole value 23, not on units 9: 09→10 and 19→20 carry normally, 23→00 wraps.
- Load validation: every nibble ≤9, SetH ≤ 8'h23, SetM ≤ 8'h59, SetS ≤ 8'h59.
  - Valid → all three registers take the set values in one cycle. No carry pulses are generated.
  - Invalid → time is unchanged and LoadErr pulses.
- Load works regardless of Pause.
- Precedence when events coincide: Load > Pause > Tick. A Tick coinciding with a Load is discarded and never deferred.
- Tick held high for k cycles counts as k seconds. There is no edge detection; the source guarantees single-cycle pulses.
- No internal state beyond the time registers and the pulse registers. There is no FSM beyond the carry chain.

## Timing
- Tick sampled high at edge N → new time visible after edge N, i.e. latency 1 cycle.
- MinTick and DayTick are high for exactly the cycle in which the wrapped value first appears. They are registered and coincident with the updated digits.
- Load at edge N → set values, or LoadErr=1, visible after edge N. LoadErr lasts 1 cycle.
- Back-to-back Tick on consecutive cycles advances on every cycle, with no lost counts.
- RST asserted mid-carry clears all outputs immediately, asynchronously. The first Tick after RST deasserts gives 00:00:01.
- Pause changes take effect on the same edge at which they are sampled.

## Structure
- Shared package clock_pkg holds:
  - BCD nibble and BCD byte typedefs.
  - Constants BCD_59=8'h59 and BCD_23=8'h23.
  - The BCD validity check function, which the display driver and alarm comparator also use.
- One sub-module, bcd_digit_pair: a two-digit BCD counter with parameter MAX, ports Inc, Load, LoadVal, Value and Wrap (combinational carry-out).
  - It is instantiated three times: seconds, minutes and hours.
  - The top module holds the load validation, the precedence logic and the pulse registers.

## Test plan
- Reset then 60 Ticks → Seconds=00, Minutes=01, one MinTick aligned with 00:01:00, DayTick never.
- Load 23:59:58, then two Ticks → 23:59:59, then 00:00:00 with MinTick=DayTick=1 in the same cycle.
- Load 09:59:59 + Tick → 10:00:00; Load 19:59:59 + Tick → 20:00:00; no DayTick in either case.
- Load 24:00:00, then 12:5A:00, then 12:60:00 → each gives LoadErr pulse, time unchanged.
- Pause=1 with 5 Ticks → time frozen. Load with Tick in the same cycle → set value appears exactly, not +1.
- Assert RST mid-run at 12:34:56 → all outputs 0 asynchronously before the next CLK edge.
